// File: rtl/jtframe_ba0_arb.sv
// Round-robin arbiter sharing SDRAM bank 0 between three read/write requesters.
// Address, data and mask are latched at grant; completion returns a one-cycle req_ok strobe.
module jtframe_ba0_arb #(
  parameter int AW = 23
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      req_rd,
  input  logic [2:0]      req_wr,
  input  logic [3*AW-1:0] req_addr,
  input  logic [47:0]     req_din,
  input  logic [5:0]      req_din_m,
  output logic [2:0]      req_ok,
  output logic [15:0]     req_dout,
  output logic [AW-1:0]   ba0_addr,
  output logic            ba0_rd,
  output logic            ba0_wr,
  output logic [15:0]     ba0_din,
  output logic [1:0]      ba0_din_m,
  input  logic            ba0_ack,
  input  logic            ba0_rdy,
  input  logic [15:0]     sdram_dout,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, CMD = 2'd1, DATA = 2'd2} state_t;

  state_t        state_r, state_s;
  logic [1:0]    ptr_r, ptr_s;
  logic [1:0]    gnt_r, gnt_s;
  logic          is_wr_r, is_wr_s;
  logic [AW-1:0] addr_r, addr_s;
  logic          rd_r, rd_s;
  logic          wr_r, wr_s;
  logic [15:0]   din_r, din_s;
  logic [1:0]    din_m_r, din_m_s;
  logic [2:0]    ok_r, ok_s;
  logic [15:0]   dout_r, dout_s;
  logic          busy_r, busy_s;

  logic [2:0]    pend_s;
  logic [1:0]    win_s;
  logic [AW-1:0] win_addr_s;
  logic [15:0]   win_din_s;
  logic [1:0]    win_din_m_s;

  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    next_idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // Search starts just after the last served requester, which ends up lowest priority
  function automatic logic [1:0] pick(input logic [2:0] pend, input logic [1:0] last);
    logic [1:0] c1, c2;
    c1 = next_idx(last);
    c2 = next_idx(c1);
    if (pend[c1]) begin
      pick = c1;
    end else if (pend[c2]) begin
      pick = c2;
    end else begin
      pick = last;
    end
  endfunction

  assign pend_s = req_rd | req_wr;
  assign win_s  = pick(pend_s, ptr_r);

  // Winner's request fields
  always_comb begin
    win_addr_s  = '0;
    win_din_s   = 16'h0000;
    win_din_m_s = 2'b00;
    case (win_s)
      2'd0: begin
        win_addr_s  = req_addr[0*AW +: AW];
        win_din_s   = req_din[15:0];
        win_din_m_s = req_din_m[1:0];
      end
      2'd1: begin
        win_addr_s  = req_addr[1*AW +: AW];
        win_din_s   = req_din[31:16];
        win_din_m_s = req_din_m[3:2];
      end
      2'd2: begin
        win_addr_s  = req_addr[2*AW +: AW];
        win_din_s   = req_din[47:32];
        win_din_m_s = req_din_m[5:4];
      end
      default: begin
        win_addr_s  = '0;
        win_din_s   = 16'h0000;
        win_din_m_s = 2'b00;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      ptr_r   <= 2'd2;
      gnt_r   <= 2'd0;
      is_wr_r <= 1'b0;
      addr_r  <= '0;
      rd_r    <= 1'b0;
      wr_r    <= 1'b0;
      din_r   <= 16'h0000;
      din_m_r <= 2'b00;
      ok_r    <= 3'b000;
      dout_r  <= 16'h0000;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      gnt_r   <= gnt_s;
      is_wr_r <= is_wr_s;
      addr_r  <= addr_s;
      rd_r    <= rd_s;
      wr_r    <= wr_s;
      din_r   <= din_s;
      din_m_r <= din_m_s;
      ok_r    <= ok_s;
      dout_r  <= dout_s;
      busy_r  <= busy_s;
    end
  end

  // Next state; ack together with rdy skips DATA entirely
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (|pend_s) begin
          state_s = CMD;
        end else begin
          state_s = IDLE;
        end
      end
      CMD: begin
        if (ba0_ack) begin
          state_s = ba0_rdy ? IDLE : DATA;
        end else begin
          state_s = CMD;
        end
      end
      DATA: begin
        if (ba0_rdy) begin
          state_s = IDLE;
        end else begin
          state_s = DATA;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Next values of the registered outputs and transaction fields
  always_comb begin
    ptr_s   = ptr_r;
    gnt_s   = gnt_r;
    is_wr_s = is_wr_r;
    addr_s  = addr_r;
    rd_s    = rd_r;
    wr_s    = wr_r;
    din_s   = din_r;
    din_m_s = din_m_r;
    ok_s    = 3'b000;
    dout_s  = dout_r;
    busy_s  = busy_r;
    case (state_r)
      IDLE: begin
        if (|pend_s) begin
          ptr_s   = win_s;
          gnt_s   = win_s;
          is_wr_s = req_wr[win_s];
          addr_s  = win_addr_s;
          din_s   = win_din_s;
          din_m_s = win_din_m_s;
          rd_s    = ~req_wr[win_s];
          wr_s    = req_wr[win_s];
          busy_s  = 1'b1;
        end else begin
          busy_s  = 1'b0;
        end
      end
      CMD: begin
        if (ba0_ack) begin
          rd_s = 1'b0;
          wr_s = 1'b0;
          if (ba0_rdy) begin
            dout_s = is_wr_r ? dout_r : sdram_dout;
            ok_s   = 3'b001 << gnt_r;
            busy_s = 1'b0;
          end else begin
            busy_s = 1'b1;
          end
        end else begin
          busy_s = 1'b1;
        end
      end
      DATA: begin
        if (ba0_rdy) begin
          dout_s = is_wr_r ? dout_r : sdram_dout;
          ok_s   = 3'b001 << gnt_r;
          busy_s = 1'b0;
        end else begin
          busy_s = 1'b1;
        end
      end
      default: begin
        rd_s   = 1'b0;
        wr_s   = 1'b0;
        busy_s = 1'b0;
      end
    endcase
  end

  assign req_ok    = ok_r;
  assign req_dout  = dout_r;
  assign ba0_addr  = addr_r;
  assign ba0_rd    = rd_r;
  assign ba0_wr    = wr_r;
  assign ba0_din   = din_r;
  assign ba0_din_m = din_m_r;
  assign busy      = busy_r;

endmodule

// File: doc/jtframe_ba0_arb.md
Name: jtframe_ba0_arb

Overview:
Round-robin arbiter that shares SDRAM bank 0, the only read/write bank, between three game-side requesters, for example CPU work RAM, a blitter and NVRAM save logic. It sits between the game module and the board's bank-0 port (ba0_addr, ba_rd[0], ba_wr[0], ba0_din, ba0_din_m, ba_ack[0], ba_rdy[0], sdram_dout). It serialises requests, latches the address and data at grant, and returns a per-requester completion strobe with the read data.

Parameters:
AW, 23, SDRAM word address width (matches SDRAMW)

Ports:
clk  in  1  system clock (clk_rom domain); single clock for the whole block
rst  in  1  synchronous, active-high reset
req_rd  in  3  per-requester read request, level, held until ok
req_wr  in  3  per-requester write request, level, held until ok
req_addr  in  3*AW  requester i at [i*AW +: AW]
req_din  in  48  write data, requester i at [i*16 +: 16]
req_din_m  in  6  write byte mask (active-high enables), requester i at [i*2 +: 2]
req_ok  out  3  one-cycle completion strobe, per requester
req_dout  out  16  last read word, shared by all requesters, valid when req_ok is high
ba0_addr  out  AW  bank-0 address to board
ba0_rd  out  1  bank-0 read strobe (drives ba_rd[0])
ba0_wr  out  1  bank-0 write strobe (drives ba_wr[0])
ba0_din  out  16  write data
ba0_din_m  out  2  write mask
ba0_ack  in  1  controller accepted the command
ba0_rdy  in  1  data valid on read, or write complete
sdram_dout  in  16  SDRAM read data
busy  out  1  high while any transaction is in flight

Behaviour:
- Reset values:
  - state IDLE; last-served pointer = 2, so requester 0 has top priority after reset.
  - All outputs 0: ba0_addr, ba0_rd, ba0_wr, ba0_din, ba0_din_m, req_ok, req_dout, busy.
- A requester is pending when req_rd[i] | req_wr[i]. If both are high, the write wins; the read is serviced on the next grant only if it is still held.
- Priority order after serving requester p is p+1, p+2, p (mod 3). The pointer updates at grant time.
- FSM states:
  - IDLE: if any requester is pending, pick the winner. On that edge, latch addr, din and din_m; set ba0_rd or ba0_wr; set busy=1; go to CMD. Otherwise stay in IDLE.
  - CMD: hold the strobe and the latched fields. On ba0_ack, clear ba0_rd and ba0_wr on the same edge and go to DATA. If ack and rdy arrive in the same cycle, go straight to completion: perform the DATA actions.
  - DATA: wait for ba0_rdy. On rdy:
    - if the transaction is a read, req_dout <= sdram_dout;
    - req_ok[g] <= 1 for exactly one cycle;
    - busy <= 0;
    - go to IDLE.
- Latency, with a request first seen high at edge n:
  - ba0_rd/ba0_wr goes high after edge n.
  - ack sampled at edge m: strobe low after edge m.
  - rdy sampled at edge k: req_ok high during cycle k+1.
  - The next grant edge is k+1; its strobe is high in cycle k+2.
- The requester must drop its rd/wr in the cycle it sees req_ok. Because the pointer has already advanced past it, a late drop cannot cause an immediate re-grant while others are pending. With no other requester pending, a still-held request is re-granted as a new transaction.
- Only the latched address and data are driven downstream. Changes to req_addr or req_din after grant have no effect on the transaction in flight.
- Request withdrawn after grant: the transaction still completes and req_ok still pulses. Request withdrawn before grant: it is ignored.
- req_dout is not updated on writes and holds its last read value.
- Reset mid-transaction: the FSM returns to IDLE, strobes drop, and no req_ok is issued. The board SDRAM controller shares rst and abandons the cycle too.
- No timeout: a missing ack or rdy stalls the FSM indefinitely, with busy held high.

Test Plan:
- Single read: req_rd=3'b001, addr0=23'h1234, ack 2 cycles after the strobe rises, rdy 5 cycles after ack with sdram_dout=16'hBEEF.
  -> ba0_addr=23'h1234, ba0_rd high exactly until ack; req_ok=3'b001 for 1 cycle with req_dout=16'hBEEF.
- Write with mask: req_wr[1]=1, din1=16'hA55A, din_m1=2'b10.
  -> ba0_wr=1, ba0_din=16'hA55A, ba0_din_m=2'b10; req_ok[1] pulses after rdy; req_dout unchanged.
- Round robin: all three requesters hold req_rd continuously and drop on their ok, then re-assert after 1 cycle.
  -> grant order 0,1,2,0,1,2; no requester is served twice while another is pending.
- Simultaneous ack+rdy in the same cycle for requester 2 read, sdram_dout=16'h0F0F.
  -> strobe low next cycle, req_ok=3'b100 next cycle, req_dout=16'h0F0F; no stall in DATA.
- Address change after grant: addr0 changes from 23'h10 to 23'h20 during CMD.
  -> ba0_addr stays 23'h10 until completion.
- Reset while in DATA.
  -> next cycle all outputs are 0 and state is IDLE; no req_ok pulse; requester 0 is served first afterwards when 0 and 1 are both pending.
